xtea_dec_stream_if: RTL and testbench

//  Upstream/downstream bridge for xtea_dec: assembles 32-bit stream words into the 128-bit
//  key and ciphertext block, pulses xtea_dec start, waits for its ready pulse with a watchdog,

---
 rtl/xtea_pkg.sv | 19 +
 rtl/xtea_word_ser.sv | 49 ++++
 rtl/xtea_dec_stream_if.sv | 133 +++++++++++++
 tb/tb_xtea_dec_stream_if.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xtea_pkg.sv
// Shared constants and FSM encoding for the xtea_dec stream bridge and its helpers.
package xtea_pkg;

  localparam int WORD_SIZE = 128;
  localparam int BUS_W     = 32;
  localparam int NW        = WORD_SIZE / BUS_W;

  // xtea_dec latency: 32 rounds of 3 cycles plus load/unload; TIMEOUT must exceed it
  localparam int DEC_ROUNDS  = 32;
  localparam int DEC_LATENCY = DEC_ROUNDS * 3 + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_SEND
  } state_t;

endpackage

// File: rtl/xtea_word_ser.sv
// Splits a captured 128-bit block into bus words, most-significant word first,
// with valid/ready handshaking and a last-word flag.
module xtea_word_ser #(
  parameter int WORD_SIZE = 128,
  parameter int BUS_W     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] block,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 done
);

  localparam int NW = WORD_SIZE / BUS_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  logic [WORD_SIZE-1:0] out_buf;
  logic [CW-1:0]        cnt;
  logic                 active;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_buf <= '0;
      cnt     <= '0;
      active  <= 1'b0;
    end else if (load) begin
      out_buf <= block;
      cnt     <= '0;
      active  <= 1'b1;
    end else if (active && out_ready) begin
      if (cnt == CW'(NW - 1)) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign out_valid = active;
  assign out_last  = active && (cnt == CW'(NW - 1));
  assign out_data  = active ? out_buf[(NW - 1 - int'(cnt)) * BUS_W +: BUS_W] : '0;
  assign done      = out_last && out_ready;

endmodule

// File: rtl/xtea_dec_stream_if.sv
// Word-stream front end for one xtea_dec: gathers key and ciphertext words, launches
// the decryptor, guards it with a watchdog and streams the plaintext back out.
module xtea_dec_stream_if
  import xtea_pkg::*;
#(
  parameter int WORD_SIZE = xtea_pkg::WORD_SIZE,
  parameter int BUS_W     = xtea_pkg::BUS_W,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_W-1:0]     in_data,
  input  logic                 in_is_key,
  output logic                 dec_start,
  output logic [WORD_SIZE-1:0] dec_data_in,
  output logic [WORD_SIZE-1:0] dec_key,
  input  logic                 dec_ready,
  input  logic [WORD_SIZE-1:0] dec_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_W-1:0]     out_data,
  output logic                 out_last,
  output logic                 err_timeout
);

  localparam int NW  = WORD_SIZE / BUS_W;
  localparam int KCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int DCW = $clog2(NW + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t               state, next_state;
  logic [WORD_SIZE-1:0] key_reg, blk_reg;
  logic [KCW-1:0]       key_cnt;
  logic [DCW-1:0]       data_cnt;
  logic                 key_loaded;
  logic [WDW-1:0]       wdog;
  logic                 data_full, in_fire, wdog_expired, ser_load, ser_done;

  assign data_full    = (data_cnt == DCW'(NW));
  assign in_fire      = in_valid && in_ready;
  assign wdog_expired = (wdog == WDW'(TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (data_full && key_loaded) next_state = ST_LAUNCH;
      ST_LAUNCH: next_state = ST_BUSY;
      ST_BUSY: begin
        if (dec_ready)         next_state = ST_SEND;
        else if (wdog_expired) next_state = ST_IDLE;
      end
      ST_SEND:   if (ser_done) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Key words stay open during BUSY/SEND because xtea_dec has already latched its key
  always_comb begin
    in_ready  = 1'b0;
    dec_start = 1'b0;
    ser_load  = 1'b0;
    if (reset) in_ready = (state != ST_LAUNCH) && !(data_full && !in_is_key);
    dec_start = (state == ST_LAUNCH);
    ser_load  = (state == ST_BUSY) && dec_ready;
  end

  // A fresh key sequence invalidates the old key from its first word onward
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_reg    <= '0;
      key_cnt    <= '0;
      key_loaded <= 1'b0;
    end else if (in_fire && in_is_key) begin
      key_reg[(NW - 1 - int'(key_cnt)) * BUS_W +: BUS_W] <= in_data;
      if (key_cnt == KCW'(NW - 1)) begin
        key_cnt    <= '0;
        key_loaded <= 1'b1;
      end else begin
        key_cnt <= key_cnt + KCW'(1);
        if (key_cnt == '0) key_loaded <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blk_reg  <= '0;
      data_cnt <= '0;
    end else if (state == ST_LAUNCH) begin
      data_cnt <= '0;
    end else if (in_fire && !in_is_key) begin
      blk_reg[(NW - 1 - int'(data_cnt)) * BUS_W +: BUS_W] <= in_data;
      data_cnt <= data_cnt + DCW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_LAUNCH)                    wdog <= '0;
      else if (state == ST_BUSY && !wdog_expired) wdog <= wdog + WDW'(1);
      if (state == ST_BUSY && !dec_ready && wdog_expired) err_timeout <= 1'b1;
    end
  end

  assign dec_key     = key_reg;
  assign dec_data_in = blk_reg;

  xtea_word_ser #(
    .WORD_SIZE (WORD_SIZE),
    .BUS_W     (BUS_W)
  ) u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load),
    .block     (dec_data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_xtea_dec_stream_if.sv
// Randomised bench for xtea_dec_stream_if with a behavioural xtea_dec stub and
// a word-level reference model of the expected block traffic.
module tb_xtea_dec_stream_if;
  import xtea_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_is_key = 1'b0;
  logic [BUS_W-1:0]     in_data = '0;
  logic                 dec_ready = 1'b0;
  logic [WORD_SIZE-1:0] dec_data_out = '0;
  logic                 out_ready = 1'b0;
  logic                 in_ready, dec_start, out_valid, out_last, err_timeout;
  logic [WORD_SIZE-1:0] dec_data_in, dec_key;
  logic [BUS_W-1:0]     out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit                   stub_en = 1'b1;
  bit                   stub_xtea = 1'b0;
  bit                   pending = 1'b0;
  int                   stub_delay = DEC_LATENCY;
  int                   start_count = 0;
  int                   start_cycle = -1;
  int                   ready_cycle = -1;
  logic [WORD_SIZE-1:0] cap_data = '0;
  logic [WORD_SIZE-1:0] cap_key = '0;

  xtea_dec_stream_if #(
    .WORD_SIZE (WORD_SIZE),
    .BUS_W     (BUS_W),
    .TIMEOUT   (255)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_is_key    (in_is_key),
    .dec_start    (dec_start),
    .dec_data_in  (dec_data_in),
    .dec_key      (dec_key),
    .dec_ready    (dec_ready),
    .dec_data_out (dec_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .err_timeout  (err_timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Textbook XTEA decipher on each 64-bit half, big-endian key words k0..k3
  function automatic logic [63:0] xtea_dec64(input logic [63:0] c, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    logic [31:0] kw [4];
    v0  = c[63:32];
    v1  = c[31:0];
    sum = 32'hC6EF3720;
    for (int i = 0; i < 4; i++) kw[i] = k[127 - 32*i -: 32];
    for (int r = 0; r < 32; r++) begin
      v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
      sum = sum - 32'h9E3779B9;
      v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [127:0] plain_of(input logic [127:0] c, input logic [127:0] k,
                                            input bit use_xtea);
    if (use_xtea) return {xtea_dec64(c[127:64], k), xtea_dec64(c[63:0], k)};
    return c ^ k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // xtea_dec stand-in: latches operands on start, answers with a one-cycle ready pulse
  initial forever begin
    @(negedge clock);
    dec_ready = 1'b0;
    if (!reset) begin
      pending = 1'b0;
    end else if (dec_start) begin
      start_count++;
      start_cycle = cyc;
      cap_data    = dec_data_in;
      cap_key     = dec_key;
      pending     = stub_en;
    end else if (pending && cyc == start_cycle + stub_delay) begin
      dec_ready    = 1'b1;
      dec_data_out = plain_of(cap_data, cap_key, stub_xtea);
      ready_cycle  = cyc;
      pending      = 1'b0;
    end
  end

  task automatic send_word(input logic is_key, input logic [31:0] w, output int acc);
    acc = -1;
    @(negedge clock);
    in_valid  = 1'b1;
    in_is_key = is_key;
    in_data   = w;
    for (int n = 0; n < 1000; n++) begin
      #1;
      if (in_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clock);
    end
    if (acc < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_word_timeout: in_ready got %b want 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic load_words(input logic is_key, input logic [127:0] v, input int first,
                            input int count, output int last_acc);
    last_acc = -1;
    for (int i = first; i < first + count; i++) send_word(is_key, v[127 - 32*i -: 32], last_acc);
  endtask

  task automatic recv_word(output logic [31:0] w, output logic last, output int vcyc);
    w    = '0;
    last = 1'b0;
    vcyc = -1;
    @(negedge clock);
    out_ready = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (out_valid === 1'b1) begin
        w         = out_data;
        last      = out_last;
        vcyc      = cyc;
        out_ready = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (vcyc < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL recv_word_timeout: out_valid got %b want 1", out_valid);
    end
  endtask

  // Returns one negedge after the last word was accepted, with out_ready dropped
  task automatic recv_block(output logic [127:0] blk, output logic [3:0] lasts,
                            output int first_cyc, output int last_cyc);
    logic [31:0] w;
    logic        l;
    int          c;
    blk = '0;
    lasts = '0;
    first_cyc = -1;
    last_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      recv_word(w, l, c);
      blk[127 - 32*i -: 32] = w;
      lasts[i] = l;
      if (i == 0) first_cyc = c;
      last_cyc = c;
    end
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic wait_start(input int prev);
    for (int n = 0; n < 1000; n++) begin
      if (start_count != prev) return;
      @(negedge clock);
      #1;
    end
    vectors++;
    miscompares++;
    $display("[TB] FAIL wait_start_timeout: start_count got %0d want %0d", start_count, prev + 1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    vectors++;
    if ({in_ready, dec_start, out_valid, out_last, err_timeout} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000",
               {in_ready, dec_start, out_valid, out_last, err_timeout});
    end
    vectors++;
    if ({dec_key, dec_data_in, out_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: key %h data %h out %h want all 0", dec_key, dec_data_in, out_data);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [127:0] key, blk, got;
    logic [3:0]   lasts;
    int           t, s0, fc, lc;
    key = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    blk = 128'h11111111_22222222_33333333_44444444;
    stub_xtea  = 1'b0;
    stub_delay = DEC_LATENCY;
    s0 = start_count;
    load_words(1'b1, key, 0, 4, t);
    load_words(1'b0, blk, 0, 4, t);
    wait_start(s0);
    vectors++;
    if (start_cycle !== t + 2) begin
      miscompares++;
      $display("[TB] FAIL basic_start_latency: got cycle %0d want %0d", start_cycle, t + 2);
    end
    vectors++;
    if (cap_key !== key || cap_data !== blk) begin
      miscompares++;
      $display("[TB] FAIL basic_operands: key %h data %h want %h %h", cap_key, cap_data, key, blk);
    end
    recv_block(got, lasts, fc, lc);
    vectors++;
    if (got !== (blk ^ key)) begin
      miscompares++;
      $display("[TB] FAIL basic_plaintext: got %h want %h", got, blk ^ key);
    end
    vectors++;
    if (lasts !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL basic_out_last: got %b want 1000", lasts);
    end
    vectors++;
    if (fc !== ready_cycle + 1) begin
      miscompares++;
      $display("[TB] FAIL basic_out_latency: got cycle %0d want %0d", fc, ready_cycle + 1);
    end
    vectors++;
    if (start_count !== s0 + 1) begin
      miscompares++;
      $display("[TB] FAIL basic_start_pulses: got %0d want %0d", start_count - s0, 1);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] key, blk, exp;
    logic [31:0]  ew;
    int           t, s0;
    bit           seen;
    key = rand128();
    blk = rand128();
    stub_delay = 30 + int'($urandom_range(0, 20));
    exp = blk ^ key;
    s0 = start_count;
    load_words(1'b1, key, 0, 4, t);
    load_words(1'b0, blk, 0, 4, t);
    wait_start(s0);
    for (int i = 0; i < 4; i++) begin
      ew = exp[127 - 32*i -: 32];
      seen = 1'b0;
      for (int n = 0; n < 1000 && !seen; n++) begin
        @(negedge clock);
        seen = (out_valid === 1'b1);
      end
      for (int s = 0; s < 10; s++) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== ew || out_last !== (i == 3)) begin
          miscompares++;
          $display("[TB] FAIL bp_hold w%0d s%0d: valid %b data %h last %b want 1 %h %b",
                   i, s, out_valid, out_data, out_last, ew, i == 3);
        end
        @(negedge clock);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
    end
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_no_extra_word: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] key, b1, b2, got;
    logic [3:0]   lasts;
    int           t, s0, fc, lc;
    key = rand128();
    b1  = rand128();
    b2  = rand128();
    stub_delay = 40;
    s0 = start_count;
    load_words(1'b1, key, 0, 4, t);
    load_words(1'b0, b1, 0, 4, t);
    wait_start(s0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      in_valid  = 1'b1;
      in_is_key = 1'b0;
      in_data   = b2[127 - 32*i -: 32];
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_busy_load w%0d: in_ready got %b want 1", i, in_ready);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
    @(negedge clock);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_data_full: in_ready got %b want 0", in_ready);
    end
    in_is_key = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_key_when_full: in_ready got %b want 1", in_ready);
    end
    in_is_key = 1'b0;
    recv_block(got, lasts, fc, lc);
    vectors++;
    if (got !== (b1 ^ key) || lasts !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL b2b_block1: got %h last %b want %h 1000", got, lasts, b1 ^ key);
    end
    in_is_key = 1'b1;
    #1;
    vectors++;
    if (dec_start !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle_gap: start %b in_ready %b want 0 1", dec_start, in_ready);
    end
    @(negedge clock);
    #1;
    vectors++;
    if (dec_start !== 1'b1 || in_ready !== 1'b0 || start_cycle !== lc + 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_relaunch: start %b in_ready %b cycle %0d want 1 0 %0d",
               dec_start, in_ready, start_cycle, lc + 2);
    end
    in_is_key = 1'b0;
    recv_block(got, lasts, fc, lc);
    vectors++;
    if (got !== (b2 ^ key)) begin
      miscompares++;
      $display("[TB] FAIL b2b_block2: got %h want %h", got, b2 ^ key);
    end
  endtask

  task automatic test_timeout();
    logic [127:0] blk, got, key;
    logic [3:0]   lasts;
    int           t, s0, l, fc, lc;
    key = rand128();
    blk = rand128();
    stub_en = 1'b0;
    s0 = start_count;
    load_words(1'b1, key, 0, 4, t);
    load_words(1'b0, blk, 0, 4, t);
    wait_start(s0);
    l = start_cycle;
    for (int n = 0; n < 1000 && cyc < l + 256; n++) @(negedge clock);
    #1;
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: err at cycle %0d got %b want 0", cyc, err_timeout);
    end
    @(negedge clock);
    #1;
    vectors++;
    if (err_timeout !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_set: err %b out_valid %b want 1 0", err_timeout, out_valid);
    end
    stub_en = 1'b1;
    stub_delay = 20;
    blk = rand128();
    s0 = start_count;
    load_words(1'b0, blk, 0, 4, t);
    wait_start(s0);
    recv_block(got, lasts, fc, lc);
    vectors++;
    if (got !== (blk ^ key) || err_timeout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_recover_sticky: got %h err %b want %h 1", got, err_timeout, blk ^ key);
    end
  endtask

  task automatic test_partial_key();
    logic [127:0] key, blk, got, exp;
    logic [3:0]   lasts;
    int           t, s0, fc, lc;
    key = rand128();
    blk = rand128();
    exp = plain_of(blk, key, 1'b1);
    stub_xtea  = 1'b1;
    stub_delay = DEC_LATENCY;
    s0 = start_count;
    load_words(1'b1, key, 0, 3, t);
    load_words(1'b0, blk, 0, 4, t);
    repeat (10) @(negedge clock);
    #1;
    vectors++;
    if (start_count !== s0) begin
      miscompares++;
      $display("[TB] FAIL partial_key_no_launch: starts got %0d want 0", start_count - s0);
    end
    load_words(1'b1, key, 3, 1, t);
    wait_start(s0);
    vectors++;
    if (start_cycle !== t + 2 || cap_key !== key) begin
      miscompares++;
      $display("[TB] FAIL partial_key_launch: cycle %0d key %h want %0d %h", start_cycle, cap_key, t + 2, key);
    end
    recv_block(got, lasts, fc, lc);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL partial_key_plaintext: got %h want %h", got, exp);
    end
    stub_xtea = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    logic [127:0] blk, key;
    logic [31:0]  w;
    logic         l;
    int           t, s0, c;
    key = rand128();
    blk = rand128();
    stub_delay = 10;
    s0 = start_count;
    load_words(1'b1, key, 0, 4, t);
    load_words(1'b0, blk, 0, 4, t);
    wait_start(s0);
    recv_word(w, l, c);
    @(negedge clock);
    out_ready = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({in_ready, dec_start, out_valid, out_last, err_timeout} !== 5'b0 || out_data !== '0
          || dec_key !== '0 || dec_data_in !== '0) begin
        miscompares++;
        $display("[TB] FAIL mid_send_reset c%0d: ctrl %b out %h want 00000 0", i,
                 {in_ready, dec_start, out_valid, out_last, err_timeout}, out_data);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_send_release: in_ready %b out_valid %b err %b want 1 0 0",
               in_ready, out_valid, err_timeout);
    end
    repeat (5) @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || dec_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_send_discard: out_valid %b start %b want 0 0", out_valid, dec_start);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_partial_key();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation time exceeded at cycle %0d", cyc);
    $fatal(1, "[TB] run aborted");
  end

endmodule
